// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the round-robin counter scheduler.
// Holds the scheduler FSM state type, the operation encoding and the default
// width constants. Modules use it through import cnt_sched_pkg::*.
package cnt_sched_pkg;

  // Default geometry of the scheduler
  localparam int NREQ_DEF = 3;
  localparam int W_DEF    = 5;
  localparam int PTRW_DEF = 2;

  // Operation encoding carried on each requester's op line
  localparam logic OP_INC = 1'b0;
  localparam logic OP_CLR = 1'b1;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr, moving upward modulo NREQ; the first
// set bit wins.
// Ports:
//   req        in  NREQ  request vector
//   ptr        in  PTRW  index where the search starts
//   win_onehot out NREQ  one-hot winner (zero when no request)
//   win_idx    out PTRW  index of the winner (zero when no request)
//   win_valid  out 1     at least one request was set
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [PTRW-1:0] win_idx,
  output logic            win_valid
);

  int              cand;
  logic [PTRW-1:0] cand_idx;
  logic            take;

  // Walk the requesters in rotated order and keep only the first hit
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    take       = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      // ptr may exceed NREQ-1 when 2^PTRW > NREQ, so wrap explicitly
      cand                 = (int'(ptr) + off) % NREQ;
      cand_idx             = PTRW'(cand);
      take                 = ~win_valid & req[cand_idx];
      win_onehot[cand_idx] = win_onehot[cand_idx] | take;
      win_idx              = take ? cand_idx : win_idx;
      win_valid            = win_valid | take;
    end
  end

endmodule

// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler in front of a shared wrapping event counter.
// Requesters ask for increment or clear through a req/ack handshake; one
// winner at a time walks IDLE -> GRANT -> DONE, so at most one op lands
// every three cycles. The counter is applied at the end of GRANT, ack is
// raised at the edge that leaves DONE, and x is cnt delayed by one cycle.
// Ports:
//   clk    in  1     clock, rising edge
//   rst    in  1     synchronous active-low reset
//   req    in  NREQ  per-requester request, held until ack
//   op     in  NREQ  per-requester op (0 increment, 1 clear), valid with req
//   freeze in  1     blocks new grants while sampled high in IDLE
//   gnt    out NREQ  one-hot grant, registered
//   ack    out NREQ  one-hot completion pulse, registered
//   cnt    out W     counter value, registered
//   x      out W     cnt delayed by one cycle
//   busy   out 1     high while the FSM is in GRANT or DONE
module cnt_rr_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int PTRW = PTRW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            freeze,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    cnt,
  output logic [W-1:0]    x,
  output logic            busy
);

  sched_state_e    state_q, state_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [PTRW-1:0] win_q, win_d;
  logic [NREQ-1:0] sel_q, sel_d;
  logic            op_q, op_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    x_q, x_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pick_onehot;
  logic [PTRW-1:0] pick_idx;
  logic            pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Next-state logic for the FSM, grant/ack, counter and snapshot
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    x_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!freeze && pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot;
          sel_d   = pick_onehot;
          win_d   = pick_idx;
          // Latch the winner's op now; later op changes are ignored
          op_d    = |(op & pick_onehot);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        state_d = ST_DONE;
        gnt_d   = '0;
        ptr_d   = (win_q == PTRW'(NREQ - 1)) ? '0 : (win_q + PTRW'(1));
        if (op_q == OP_CLR) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      ST_DONE: begin
        // ack becomes visible on the edge that returns to IDLE
        state_d = ST_IDLE;
        gnt_d   = '0;
        ack_d   = sel_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      op_q    <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign cnt  = cnt_q;
  assign x    = x_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Self-checking bench for cnt_rr_sched: directed scenarios followed by
// randomized requesters, compared every cycle against a timeline model
// (edge numbers of the last grant decide when cnt, ack and busy change).
module tb_cnt_rr_sched;

  localparam int NREQ = 3;
  localparam int W    = 5;
  localparam int PTRW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] op = '0;
  logic            freeze = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    cnt;
  logic [W-1:0]    x;
  logic            busy;

  cnt_rr_sched #(.NREQ(NREQ), .W(W), .PTRW(PTRW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .freeze (freeze),
    .gnt    (gnt),
    .ack    (ack),
    .cnt    (cnt),
    .x      (x),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int              edge_no = 0;
  int              g_edge  = -100;
  int              m_cnt   = 0;
  int              m_x     = 0;
  int              m_ptr   = 0;
  int              m_win   = 0;
  logic            m_op    = 1'b0;
  logic [NREQ-1:0] exp_gnt = '0;
  logic [NREQ-1:0] exp_ack = '0;
  logic            exp_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    edge_no++;
    if (!rst) begin
      m_cnt    = 0;
      m_x      = 0;
      m_ptr    = 0;
      g_edge   = -100;
      exp_gnt  = '0;
      exp_ack  = '0;
      exp_busy = 1'b0;
    end else begin
      m_x = m_cnt;
      if (edge_no == g_edge + 1) begin
        m_cnt = m_op ? 0 : (m_cnt + 1) % (1 << W);
      end
      exp_ack = (edge_no == g_edge + 2) ? NREQ'(1 << m_win) : '0;
      if (edge_no >= g_edge + 3 && !freeze && req != '0) begin
        for (int off = 0; off < NREQ; off++) begin
          int i;
          i = (m_ptr + off) % NREQ;
          if (req[i]) begin
            m_win = i;
            break;
          end
        end
        m_op   = op[m_win];
        m_ptr  = (m_win + 1) % NREQ;
        g_edge = edge_no;
      end
      exp_gnt  = (edge_no == g_edge) ? NREQ'(1 << m_win) : '0;
      exp_busy = (edge_no == g_edge) || (edge_no == g_edge + 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", gnt, exp_gnt);
    check("ack", ack, exp_ack);
    check("cnt", cnt, m_cnt);
    check("x", x, m_x);
    check("busy", busy, exp_busy);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (exp_ack[i] && $urandom_range(3) != 0) req[i] = 1'b0;
        else if ($urandom_range(15) == 0) req[i] = 1'b0;
        else if ($urandom_range(7) == 0) op[i] = ~op[i];
        else req[i] = 1'b1;
      end else if ($urandom_range(2) == 0) begin
        req[i] = 1'b1;
        op[i]  = 1'($urandom_range(1));
      end else begin
        req[i] = 1'b0;
      end
    end
    freeze = ($urandom_range(7) == 0);
    rst    = ($urandom_range(199) != 0);
  endtask

  logic [8:0] order;

  initial begin
    // Reset held for two cycles with all requests pending
    rst = 1'b0; req = 3'b111; op = 3'b000; freeze = 1'b0;
    step();
    step();
    check("rst_gnt", gnt, 3'b000);

    // Single increment: gnt at edge 1, cnt at edge 2, ack and x at edge 3
    rst = 1'b1; req = 3'b001; op = 3'b000;
    step(); check("t2_gnt_e1", gnt, 3'b001);
    step(); check("t2_cnt_e2", cnt, 5'd1);
    step(); check("t2_ack_e3", ack, 3'b001); check("t2_x_e3", x, 5'd1);
    req = 3'b000;
    step();
    step();

    // Three simultaneous requesters served in rotation
    do_reset();
    req = 3'b111; op = 3'b000; order = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (gnt != 3'b000) order = {order[5:0], gnt};
    end
    check("t3_order", order, 9'b001_010_100);
    check("t3_cnt", cnt, 5'd3);
    req = 3'b011;
    step(); check("t3_ptr_wrap", gnt, 3'b001);
    req = 3'b000;
    step();
    step();

    // Wrap from 31 to 0 after 32 increments
    do_reset();
    req = 3'b001; op = 3'b000;
    repeat (94) step();
    step(); check("t4_wrap_cnt", cnt, 5'd0); check("t4_x31", x, 5'd31);
    step(); check("t4_wrap_x", x, 5'd0);
    req = 3'b000;
    step();

    // cnt=7 with ptr=1: requester 1 clears first, then requester 0 increments
    do_reset();
    req = 3'b001; op = 3'b000;
    repeat (21) step();
    check("t5_cnt7", cnt, 5'd7);
    req = 3'b011; op = 3'b010;
    step(); check("t5_gnt1", gnt, 3'b010);
    step(); check("t5_clr", cnt, 5'd0);
    step();
    step(); check("t5_gnt0", gnt, 3'b001);
    step(); check("t5_inc", cnt, 5'd1);
    req = 3'b000;
    step();
    step();

    // Freeze blocks grants and holds cnt; release grants on the next edge
    freeze = 1'b1; req = 3'b001; op = 3'b000;
    repeat (5) begin
      step();
      check("t6_frz_gnt", gnt, 3'b000);
      check("t6_frz_cnt", cnt, 5'd1);
    end
    freeze = 1'b0;
    step(); check("t6_unfrz_gnt", gnt, 3'b001);
    // Reset during GRANT aborts the operation
    rst = 1'b0;
    step(); check("t6_abort_cnt", cnt, 5'd0); check("t6_abort_busy", busy, 1'b0);
    rst = 1'b1; req = 3'b000;
    repeat (3) begin
      step();
      check("t6_no_ack", ack, 3'b000);
    end

    // Randomized traffic with freeze and occasional reset
    repeat (3000) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
